// File: rtl/pin_auth_engine_pkg.sv
// pin_auth_engine_pkg: shared definitions for the account authenticator.
//   - FSM state encoding (state_t), also exported on the debug port
//   - response status codes (AUTH_*) and request op codes (OP_*)
//   - default_pin(): PIN loaded into each database entry at reset
// Optional feature macro used by the design: AUTH_LOCKOUT_EN.
package pin_auth_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEARCH = 3'd1,
    S_CHECK  = 3'd2,
    S_UPDATE = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [2:0] AUTH_OK        = 3'd0;
  localparam logic [2:0] AUTH_NOT_FOUND = 3'd1;
  localparam logic [2:0] AUTH_BAD_PIN   = 3'd2;
  localparam logic [2:0] AUTH_LOCKED    = 3'd3;
  localparam logic [2:0] AUTH_SAME_PIN  = 3'd4;

  localparam logic OP_AUTH       = 1'b0;
  localparam logic OP_CHANGE_PIN = 1'b1;

  // Factory PIN of database entry i (decimal values); entries past the
  // tenth start with PIN 0.
  function automatic int unsigned default_pin(input int i);
    int unsigned pin;
    case (i)
      0:       pin = 1234;
      1:       pin = 2345;
      2:       pin = 3456;
      3:       pin = 4567;
      4:       pin = 5678;
      5:       pin = 6789;
      6:       pin = 7890;
      7:       pin = 8901;
      8:       pin = 9012;
      9:       pin = 7123;
      default: pin = 0;
    endcase
    return pin;
  endfunction

endpackage

// File: rtl/pin_auth_engine_if.sv
// pin_auth_engine_if: request/response bus of the authenticator.
//   req_*  : one request (op, account, PIN, new PIN) from the front end
//   rsp_*  : one response (status, matched index) to the controller
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both 1. The source holds valid and its payload stable until
// that edge; ready may change freely. The engine raises req_ready only in
// IDLE and holds rsp_valid/status/index steady until rsp_ready is seen.
// Modports: master = front end / controller side, slave = engine.
interface pin_auth_engine_if #(
  parameter int ACC_W = 4,
  parameter int PIN_W = 16,
  parameter int IDX_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [ACC_W-1:0] req_acc;
  logic [PIN_W-1:0] req_pin;
  logic [PIN_W-1:0] req_new_pin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       rsp_status;
  logic [IDX_W-1:0] rsp_index;

  modport master (
    output req_valid, req_op, req_acc, req_pin, req_new_pin, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_index
  );

  modport slave (
    input  req_valid, req_op, req_acc, req_pin, req_new_pin, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_index
  );
endinterface

// File: rtl/pin_auth_engine_account_db.sv
// pin_auth_engine_account_db: account/PIN register file of the engine.
//   clk, rst_n   : rising-edge clock, synchronous active-low reset that
//                  reloads the factory contents (entry i = account i+1)
//   idx          : shared read/write index
//   rd_acc/rd_pin: combinational read of entry[idx]
//   rd_locked    : entry[idx] has reached the fail limit
//   wr_en/wr_pin : write a new PIN into entry[idx]
//   fail_inc/clr : bump (saturating) or clear the fail counter of entry[idx]
// With AUTH_LOCKOUT_EN defined each entry carries a 3-bit fail counter;
// otherwise there are no counters and rd_locked is tied low.
module pin_auth_engine_account_db
  import pin_auth_engine_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 10,
  parameter int ACC_W        = 4,
  parameter int PIN_W        = 16,
  parameter int IDX_W        = 4,
  parameter int MAX_TRIES    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  output logic [ACC_W-1:0] rd_acc,
  output logic [PIN_W-1:0] rd_pin,
  output logic             rd_locked,
  input  logic             wr_en,
  input  logic [PIN_W-1:0] wr_pin,
  input  logic             fail_inc,
  input  logic             fail_clr
);

  logic [ACC_W-1:0] acc_mem [NUM_ACCOUNTS];
  logic [PIN_W-1:0] pin_mem [NUM_ACCOUNTS];

  // Reload takes priority over a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        acc_mem[i] <= ACC_W'(i + 1);
        pin_mem[i] <= PIN_W'(default_pin(i));
      end
    end else if (wr_en) begin
      pin_mem[idx] <= wr_pin;
    end
  end

  assign rd_acc = acc_mem[idx];
  assign rd_pin = pin_mem[idx];

`ifdef AUTH_LOCKOUT_EN
  localparam logic [2:0] MAX_CNT = 3'(MAX_TRIES);

  logic [2:0] fail_cnt [NUM_ACCOUNTS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        fail_cnt[i] <= 3'd0;
      end
    end else if (fail_clr) begin
      fail_cnt[idx] <= 3'd0;
    end else if (fail_inc && (fail_cnt[idx] != MAX_CNT)) begin
      fail_cnt[idx] <= fail_cnt[idx] + 3'd1;
    end
  end

  // Once at the limit the counter only leaves it through reset.
  assign rd_locked = (fail_cnt[idx] == MAX_CNT);
`else
  logic unused_lockout;
  assign unused_lockout = ^{fail_inc, fail_clr, 3'(MAX_TRIES)};
  assign rd_locked      = 1'b0;
`endif

endmodule

// File: rtl/pin_auth_engine.sv
// pin_auth_engine: sequential account authenticator and PIN manager.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset (drops any request in flight)
//   bus       : pin_auth_engine_if.slave request/response handshake
//   dbg_state : current FSM state
// Flow: IDLE -> SEARCH (one database entry per clock, lowest index wins)
//       -> CHECK -> (UPDATE for a real PIN change) -> RESP -> IDLE.
// Optional macro AUTH_LOCKOUT_EN enables per-account fail counters and
// the LOCKED status (handled inside pin_auth_engine_account_db).
module pin_auth_engine
  import pin_auth_engine_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 10,
  parameter int ACC_W        = 4,
  parameter int PIN_W        = 16,
  parameter int IDX_W        = 4,
  parameter int MAX_TRIES    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pin_auth_engine_if.slave        bus,
  output state_t                  dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCOUNTS - 1);

  state_t           state_q, state_d;
  logic             op_q;
  logic [ACC_W-1:0] acc_q;
  logic [PIN_W-1:0] pin_q;
  logic [PIN_W-1:0] new_pin_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [2:0]       status_q, status_d;

  logic             capture;
  logic             wr_en;
  logic             fail_inc;
  logic             fail_clr;
  logic             hit;
  logic [ACC_W-1:0] rd_acc;
  logic [PIN_W-1:0] rd_pin;
  logic             rd_locked;

  pin_auth_engine_account_db #(
    .NUM_ACCOUNTS (NUM_ACCOUNTS),
    .ACC_W        (ACC_W),
    .PIN_W        (PIN_W),
    .IDX_W        (IDX_W),
    .MAX_TRIES    (MAX_TRIES)
  ) u_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx_q),
    .rd_acc    (rd_acc),
    .rd_pin    (rd_pin),
    .rd_locked (rd_locked),
    .wr_en     (wr_en),
    .wr_pin    (new_pin_q),
    .fail_inc  (fail_inc),
    .fail_clr  (fail_clr)
  );

  // Account 0 is reserved and never matches any entry.
  assign hit = (acc_q != '0) && (rd_acc == acc_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      index_q  <= '0;
      status_q <= AUTH_OK;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      index_q  <= index_d;
      status_q <= status_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= OP_AUTH;
      acc_q     <= '0;
      pin_q     <= '0;
      new_pin_q <= '0;
    end else if (capture) begin
      op_q      <= bus.req_op;
      acc_q     <= bus.req_acc;
      pin_q     <= bus.req_pin;
      new_pin_q <= bus.req_new_pin;
    end
  end

  // idx_q doubles as the scan pointer and, after a hit, the matched index:
  // it simply stops advancing, so the database port keeps addressing the
  // matched entry through CHECK and UPDATE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    index_d  = index_q;
    status_d = status_q;
    capture  = 1'b0;
    wr_en    = 1'b0;
    fail_inc = 1'b0;
    fail_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (hit) begin
          state_d = S_CHECK;
        end else if (idx_q == LAST_IDX) begin
          status_d = AUTH_NOT_FOUND;
          index_d  = '0;
          state_d  = S_RESP;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_CHECK: begin
        index_d = idx_q;
        state_d = S_RESP;
        if (rd_locked) begin
          status_d = AUTH_LOCKED;
        end else if (rd_pin != pin_q) begin
          status_d = AUTH_BAD_PIN;
          fail_inc = 1'b1;
        end else if (op_q == OP_AUTH) begin
          status_d = AUTH_OK;
          fail_clr = 1'b1;
        end else if (new_pin_q == rd_pin) begin
          status_d = AUTH_SAME_PIN;
          fail_clr = 1'b1;
        end else begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        wr_en    = 1'b1;
        fail_clr = 1'b1;
        status_d = AUTH_OK;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_status = status_q;
  assign bus.rsp_index  = index_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_pin_auth_engine.sv
// tb_pin_auth_engine: bench for pin_auth_engine. A driver issues requests
// and pushes the reference model's expected {status, index, rise cycle}
// into exp_q; a monitor pops and compares on every response handshake.
// A response whose valid is sampled high at edge T+n first shows up in the
// half-cycle after edge T+n-1, which is where the monitor timestamps it.
module tb_pin_auth_engine;
  import pin_auth_engine_pkg::*;

  localparam int NUM       = 10;
  localparam int ACC_W     = 4;
  localparam int PIN_W     = 16;
  localparam int IDX_W     = 4;
  localparam int MAX_TRIES = 3;
  localparam int EXP_W     = 3 + IDX_W + 32;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  pin_auth_engine_if #(.ACC_W(ACC_W), .PIN_W(PIN_W), .IDX_W(IDX_W)) bus ();

  pin_auth_engine #(
    .NUM_ACCOUNTS (NUM),
    .ACC_W        (ACC_W),
    .PIN_W        (PIN_W),
    .IDX_W        (IDX_W),
    .MAX_TRIES    (MAX_TRIES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int ready_mode = 2;  // 0 random, 1 held low, 2 held high

  logic [EXP_W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  int               reset_pins [NUM] = '{1234, 2345, 3456, 4567, 5678,
                                         6789, 7890, 8901, 9012, 7123};
  logic [ACC_W-1:0] m_acc  [NUM];
  logic [PIN_W-1:0] m_pin  [NUM];
  int               m_fail [NUM];

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_acc[i]  = ACC_W'(i + 1);
      m_pin[i]  = PIN_W'(reset_pins[i]);
      m_fail[i] = 0;
    end
  endtask

  task automatic model_exec(input logic op, input logic [ACC_W-1:0] acc,
                            input logic [PIN_W-1:0] pin,
                            input logic [PIN_W-1:0] new_pin,
                            output logic [2:0] st, output logic [IDX_W-1:0] ix,
                            output int lat);
    int k;
    bit locked;
    k = -1;
    for (int i = NUM - 1; i >= 0; i--)
      if (acc != '0 && m_acc[i] == acc) k = i;
    if (k < 0) begin
      st = 3'd1; ix = '0; lat = NUM;
    end else begin
      ix  = IDX_W'(k);
      lat = k + 2;
      locked = 1'b0;
`ifdef AUTH_LOCKOUT_EN
      locked = (m_fail[k] == MAX_TRIES);
`endif
      if (locked) begin
        st = 3'd3;
      end else if (m_pin[k] != pin) begin
        st = 3'd2;
        if (m_fail[k] < MAX_TRIES) m_fail[k]++;
      end else if (op == 1'b0) begin
        st = 3'd0; m_fail[k] = 0;
      end else if (new_pin == m_pin[k]) begin
        st = 3'd4; m_fail[k] = 0;
      end else begin
        st = 3'd0; m_fail[k] = 0; m_pin[k] = new_pin; lat = k + 3;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // use_exp substitutes fixed expectations for the model's result; the
  // model is still stepped so it stays in sync with the database.
  task automatic send(input logic op, input logic [ACC_W-1:0] acc,
                      input logic [PIN_W-1:0] pin, input logic [PIN_W-1:0] new_pin,
                      input bit use_exp, input logic [2:0] e_st,
                      input logic [IDX_W-1:0] e_ix, input int e_lat);
    int guard;
    int t;
    int lat;
    logic [2:0] st;
    logic [IDX_W-1:0] ix;
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: req_ready=0, required 1 within 400 cycles");
      return;
    end
    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.req_acc     = acc;
    bus.req_pin     = pin;
    bus.req_new_pin = new_pin;
    @(posedge clk);
    #1;
    t = cyc;
    bus.req_valid = 1'b0;
    model_exec(op, acc, pin, new_pin, st, ix, lat);
    if (use_exp) begin
      st = e_st; ix = e_ix; lat = e_lat;
    end
    exp_q.push_back({st, ix, 32'(t + lat)});
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !bus.req_ready) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 600) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic wait_rsp_valid(output bit ok);
    int guard;
    guard = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!bus.rsp_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.rsp_valid) begin
      ok = 1'b0;
      checks++; errors++;
      $display("FAIL rsp_valid_timeout: rsp_valid=0, required 1 within 100 cycles");
    end
  endtask

  task automatic check1(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // ---------------- rsp_ready driver ----------------
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
        1:       bus.rsp_ready = 1'b0;
        default: bus.rsp_ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  bit               in_rsp = 1'b0;
  int               rise_cyc = 0;
  logic [2:0]       held_st;
  logic [IDX_W-1:0] held_ix;

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst_n && bus.rsp_valid) begin
      if (!in_rsp) begin
        in_rsp   = 1'b1;
        rise_cyc = cyc;
        held_st  = bus.rsp_status;
        held_ix  = bus.rsp_index;
      end else begin
        checks++;
        if (bus.rsp_status != held_st || bus.rsp_index != held_ix) begin
          errors++;
          $display("FAIL rsp_stable: got status %0d index %0d, required %0d %0d",
                   bus.rsp_status, bus.rsp_index, held_st, held_ix);
        end
      end
      if (bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got status %0d index %0d, required no response",
                   bus.rsp_status, bus.rsp_index);
        end else begin
          e = exp_q.pop_front();
          checks += 3;
          if (bus.rsp_status != e[EXP_W-1 -: 3]) begin
            errors++;
            $display("FAIL rsp_status: got %0d, required %0d", bus.rsp_status, e[EXP_W-1 -: 3]);
          end
          if (bus.rsp_index != e[32 +: IDX_W]) begin
            errors++;
            $display("FAIL rsp_index: got %0d, required %0d", bus.rsp_index, e[32 +: IDX_W]);
          end
          if (rise_cyc != int'(e[31:0])) begin
            errors++;
            $display("FAIL rsp_latency: rose at cycle %0d, required %0d", rise_cyc, e[31:0]);
          end
        end
        in_rsp = 1'b0;
      end
    end else begin
      in_rsp = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    logic op;
    logic [ACC_W-1:0] acc;
    logic [PIN_W-1:0] pin, new_pin;
    int guard;

    bus.req_valid   = 1'b0;
    bus.req_op      = 1'b0;
    bus.req_acc     = '0;
    bus.req_pin     = '0;
    bus.req_new_pin = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check1("reset_req_ready", int'(bus.req_ready), 1);
    check1("reset_rsp_valid", int'(bus.rsp_valid), 0);
    check1("reset_rsp_status", int'(bus.rsp_status), 0);
    check1("reset_rsp_index", int'(bus.rsp_index), 0);

    // Directed cases with fixed expectations.
    ready_mode = 2;
    send(1'b0, 4'd3, 16'd3456, 16'd0, 1, 3'd0, 4'd2, 4);
    send(1'b0, 4'd12, 16'd1, 16'd0, 1, 3'd1, 4'd0, 10);
    send(1'b0, 4'd0, 16'd0, 16'd0, 1, 3'd1, 4'd0, 10);
    send(1'b1, 4'd1, 16'd1234, 16'd4321, 1, 3'd0, 4'd0, 3);
    send(1'b0, 4'd1, 16'd1234, 16'd0, 1, 3'd2, 4'd0, 2);
    send(1'b0, 4'd1, 16'd4321, 16'd0, 1, 3'd0, 4'd0, 2);
    send(1'b1, 4'd1, 16'd4321, 16'd4321, 1, 3'd4, 4'd0, 2);
    send(1'b0, 4'd10, 16'd7123, 16'd0, 1, 3'd0, 4'd9, 11);
    send(1'b1, 4'd7, 16'd1111, 16'd2222, 1, 3'd2, 4'd6, 8);
    drain();

    // Repeated bad PINs on account 5.
    do_reset();
    repeat (3) send(1'b0, 4'd5, 16'd1, 16'd0, 1, 3'd2, 4'd4, 6);
`ifdef AUTH_LOCKOUT_EN
    send(1'b0, 4'd5, 16'd5678, 16'd0, 1, 3'd3, 4'd4, 6);
    send(1'b1, 4'd5, 16'd5678, 16'd9999, 1, 3'd3, 4'd4, 6);
    drain();
    do_reset();
    send(1'b0, 4'd5, 16'd5678, 16'd0, 1, 3'd0, 4'd4, 6);
`else
    send(1'b0, 4'd5, 16'd1, 16'd0, 1, 3'd2, 4'd4, 6);
    send(1'b0, 4'd5, 16'd5678, 16'd0, 1, 3'd0, 4'd4, 6);
`endif
    drain();

    // Response held for 5 cycles; a second request must be ignored.
    ready_mode = 1;
    send(1'b0, 4'd2, 16'd2345, 16'd0, 1, 3'd0, 4'd1, 3);
    wait_rsp_valid(ok);
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        check1("hold_req_ready", int'(bus.req_ready), 0);
        check1("hold_rsp_valid", int'(bus.rsp_valid), 1);
        if (i == 1) begin
          bus.req_valid = 1'b1; bus.req_op = 1'b0;
          bus.req_acc = 4'd1; bus.req_pin = 16'd1234;
        end
        if (i == 4) bus.req_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.req_valid = 1'b0;
    ready_mode = 2;
    drain();

    // rsp_ready already high: one-cycle response, ready right after.
    send(1'b0, 4'd4, 16'd4567, 16'd0, 1, 3'd0, 4'd3, 5);
    wait_rsp_valid(ok);
    if (ok) begin
      @(negedge clk);
      check1("fast_rsp_valid_drop", int'(bus.rsp_valid), 0);
      check1("fast_req_ready_back", int'(bus.req_ready), 1);
    end
    drain();

    // Reset during SEARCH drops the request.
    send(1'b0, 4'd10, 16'd7123, 16'd0, 0, 3'd0, 4'd0, 0);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check1("midreset_req_ready", int'(bus.req_ready), 1);
    check1("midreset_rsp_valid", int'(bus.rsp_valid), 0);
    rst_n = 1'b1;
    send(1'b0, 4'd1, 16'd1234, 16'd0, 1, 3'd0, 4'd0, 2);
    drain();

    // Reset on the UPDATE edge: the reload wins over the PIN write.
    send(1'b1, 4'd2, 16'd2345, 16'd9999, 0, 3'd0, 4'd0, 0);
    void'(exp_q.pop_back());
    guard = 0;
    @(negedge clk);
    while (dbg_state != S_UPDATE && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check1("reach_update_state", int'(dbg_state == S_UPDATE), 1);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 4'd2, 16'd2345, 16'd0, 1, 3'd0, 4'd1, 3);
    send(1'b0, 4'd2, 16'd9999, 16'd0, 1, 3'd2, 4'd1, 3);
    drain();

    // Randomized traffic against the model.
    ready_mode = 0;
    repeat (60) begin
      op  = 1'($urandom_range(0, 1));
      acc = ACC_W'($urandom_range(0, 15));
      if (acc >= 1 && acc <= NUM && $urandom_range(0, 2) != 0)
        pin = m_pin[int'(acc) - 1];
      else
        pin = PIN_W'($urandom);
      new_pin = ($urandom_range(0, 3) == 0) ? pin : PIN_W'($urandom);
      send(op, acc, pin, new_pin, 0, 3'd0, 4'd0, 0);
    end
    drain();

    check1("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
